door_ctrl: RTL
==============

# door_ctrl

Sequential, parametrised door controller for the elevator car. It replaces the combinational door decode with a four-state door FSM that has a modelled door travel time, a hold-open timer, reopen on obstruction, a move-permission handshake to the motion controller and a sticky safety fault. It sits between the motion controller (`moving`), the floor sensors, and the car buttons and safety edge.

## Interface
Parameters:
- N_FLOORS, 3, number of floors and width of the floor sensor vector (≥2)
- TRAVEL_CYCLES, 4, cycles for a full open or full close stroke (≥1)
- OPEN_CYCLES, 8, hold-open reload value (≥1)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- moving  in  1  car in motion, from the motion controller
- at_floor  in  N_FLOORS  floor sensors; valid only when exactly one bit is set
- open_req  in  1  door-open button, level
- close_req  in  1  door-close button, level
- obstruct  in  1  safety edge or light curtain, level
- door_state  out  2  CLOSED=00, OPENING=01, OPEN=10, CLOSING=11
- door_open  out  1  state==OPEN
- door_closed  out  1  state==CLOSED
- ok_to_move  out  1  state==CLOSED && !open_req && !fault
- door_floor  out  N_FLOORS  at_floor latched at the open trigger
- fault  out  1  sticky; set when moving is high while the door is not CLOSED

## Operation
- Registers: state, pos (0..TRAVEL_CYCLES, width $clog2(TRAVEL_CYCLES+1)), hold (0..OPEN_CYCLES, width $clog2(OPEN_CYCLES+1)), moving_d, door_floor, fault.
- pos models the door position: 0 is shut and TRAVEL_CYCLES is fully open. It never wraps and saturates in both directions.
- Open trigger, sampled in CLOSED: (open_req OR falling edge of moving, i.e. moving_d & !moving) AND !moving AND at_floor is one-hot. A zero or multi-hot at_floor blocks the trigger.
- CLOSED, on trigger: go to OPENING and latch door_floor=at_floor.
- OPENING: pos increments on each edge. On the edge where pos reaches TRAVEL_CYCLES, go to OPEN and load hold=OPEN_CYCLES. close_req is ignored.
- OPEN, in priority order:
  - obstruct or open_req reloads hold to OPEN_CYCLES.
  - Otherwise, close_req or hold==0 goes to CLOSING.
  - Otherwise hold decrements.
- CLOSING: obstruct or open_req goes to OPENING with pos retained, so the reopen takes TRAVEL_CYCLES−pos edges. Otherwise pos decrements. On the edge where pos reaches 0, go to CLOSED.
- Fault:
  - moving==1 with state≠CLOSED sets fault on the next edge.
  - While fault is set, state, pos and hold freeze and ok_to_move=0.
  - Only rst_n clears fault.
- door_floor holds its value until the next trigger.

## Timing
- Reset (async, immediate, including mid-stroke): state=CLOSED, pos=0, hold=0, moving_d=0, door_floor=0, fault=0. Outputs: door_state=00, door_closed=1, door_open=0, ok_to_move=1 (given open_req=0).
- Outputs decode registered state combinationally. There is no extra output latency.
- With a trigger sampled at edge k and no further events:
  - OPENING from k, OPEN from k+TRAVEL_CYCLES.
  - OPEN lasts OPEN_CYCLES+1 cycles.
  - CLOSING from k+TRAVEL_CYCLES+OPEN_CYCLES+1.
  - CLOSED at k+2·TRAVEL_CYCLES+OPEN_CYCLES+1.
- close_req in OPEN gives CLOSING on the next edge. obstruct in the same cycle wins.
- Obstruct and close_req together in CLOSING: reopen wins.
- ok_to_move drops combinationally with open_req, so the motion controller must sample it before asserting moving.

## Test plan
All scenarios use the default parameters.
- **Reset:** hold rst_n=0, then release → door_state=00, door_closed=1, ok_to_move=1, fault=0, door_floor=000. Assert rst_n=0 mid-OPENING → all outputs return to these values immediately, without waiting for a clock edge.
- **Arrival:** moving 1→0 with at_floor=010, trigger at edge k → door_floor=010, door_open from k+4 to k+12, CLOSING at k+13, door_closed and ok_to_move at k+17.
- **Reopen:** obstruct for one cycle when pos=2 in CLOSING → OPENING next edge, door_open 2 edges later, hold reloaded to 8.
- **Close button:** close_req in OPEN → CLOSING next edge. close_req together with obstruct → stays OPEN and hold is reloaded to 8 each cycle obstruct is held.
- **Invalid floor:** open_req with at_floor=000, then with 011, while stopped → stays CLOSED, door_floor unchanged. open_req with moving=1 → stays CLOSED.
- **Fault:** moving=1 while OPEN → fault=1 next edge, state frozen at 10, ok_to_move=0. Dropping moving keeps fault=1 until rst_n is pulsed.

Source files
------------

// File: rtl/door_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : door_ctrl
// Purpose  : Elevator car door controller. A four-state door FSM with a
//            modelled door travel time, a hold-open timer, reopen on
//            obstruction, a move-permission output and a sticky safety fault.
// Ports    : clk, rst_n      - clock (rising edge), async active-low reset
//            moving          - car in motion, from the motion controller
//            at_floor        - floor sensors, valid only when one-hot
//            open_req        - door-open button (level)
//            close_req       - door-close button (level)
//            obstruct        - safety edge / light curtain (level)
//            door_state      - CLOSED=00 OPENING=01 OPEN=10 CLOSING=11
//            door_open       - door fully open
//            door_closed     - door fully shut
//            ok_to_move      - motion controller may start the car
//            door_floor      - floor latched when the door last opened
//            fault           - sticky: car moved with the door not shut
// Revision : 1.0 - initial release
// ============================================================================
module door_ctrl #(
  parameter int N_FLOORS      = 3,
  parameter int TRAVEL_CYCLES = 4,
  parameter int OPEN_CYCLES   = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                moving,
  input  logic [N_FLOORS-1:0] at_floor,
  input  logic                open_req,
  input  logic                close_req,
  input  logic                obstruct,
  output logic [1:0]          door_state,
  output logic                door_open,
  output logic                door_closed,
  output logic                ok_to_move,
  output logic [N_FLOORS-1:0] door_floor,
  output logic                fault
);

  localparam int POS_W  = $clog2(TRAVEL_CYCLES + 1);
  localparam int HOLD_W = $clog2(OPEN_CYCLES + 1);

  localparam logic [1:0] S_CLOSED  = 2'b00;
  localparam logic [1:0] S_OPENING = 2'b01;
  localparam logic [1:0] S_OPEN    = 2'b10;
  localparam logic [1:0] S_CLOSING = 2'b11;

  localparam logic [POS_W-1:0]    C_POS_FULL  = POS_W'(TRAVEL_CYCLES);
  localparam logic [POS_W-1:0]    C_POS_LAST  = POS_W'(TRAVEL_CYCLES - 1);
  localparam logic [POS_W-1:0]    C_POS_ONE   = POS_W'(1);
  localparam logic [HOLD_W-1:0]   C_HOLD_FULL = HOLD_W'(OPEN_CYCLES);
  localparam logic [HOLD_W-1:0]   C_HOLD_ONE  = HOLD_W'(1);
  localparam logic [N_FLOORS-1:0] C_FLOOR_ONE = N_FLOORS'(1);

  logic [1:0]          r_state;
  logic [POS_W-1:0]    r_pos;
  logic [HOLD_W-1:0]   r_hold;
  logic                r_moving_d;
  logic [N_FLOORS-1:0] r_door_floor;
  logic                r_fault;

  logic [1:0]          w_state_nx;
  logic [POS_W-1:0]    w_pos_nx;
  logic [HOLD_W-1:0]   w_hold_nx;
  logic [N_FLOORS-1:0] w_floor_nx;
  logic                w_fault_nx;
  logic                w_floor_valid;
  logic                w_trigger;
  logic                w_reopen;

  // Exactly one floor sensor active: non-zero and clearing the lowest set
  // bit leaves nothing behind.
  assign w_floor_valid = (at_floor != '0) &&
                         ((at_floor & (at_floor - C_FLOOR_ONE)) == '0);

  // Arrival (falling edge of moving) or the open button, only when stopped
  // at a well-defined floor and not in fault.
  assign w_trigger = (open_req | (r_moving_d & ~moving)) & ~moving &
                     w_floor_valid & ~r_fault;

  assign w_reopen   = obstruct | open_req;
  assign w_fault_nx = r_fault | (moving & (r_state != S_CLOSED));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_CLOSED;
      r_pos        <= '0;
      r_hold       <= '0;
      r_moving_d   <= 1'b0;
      r_door_floor <= '0;
      r_fault      <= 1'b0;
    end else begin
      r_state      <= w_state_nx;
      r_pos        <= w_pos_nx;
      r_hold       <= w_hold_nx;
      r_moving_d   <= moving;
      r_door_floor <= w_floor_nx;
      r_fault      <= w_fault_nx;
    end
  end

  // Next-state logic; everything freezes once a fault is latched.
  always_comb begin
    w_state_nx = r_state;
    w_pos_nx   = r_pos;
    w_hold_nx  = r_hold;
    w_floor_nx = r_door_floor;
    if (!r_fault) begin
      case (r_state)
        S_CLOSED: begin
          if (w_trigger) begin
            w_state_nx = S_OPENING;
            w_floor_nx = at_floor;
          end
        end
        S_OPENING: begin
          // A reopen right at the start of CLOSING can arrive here with the
          // door already fully open; saturate and finish on this edge.
          if (r_pos >= C_POS_LAST) begin
            w_pos_nx   = C_POS_FULL;
            w_state_nx = S_OPEN;
            w_hold_nx  = C_HOLD_FULL;
          end else begin
            w_pos_nx = r_pos + C_POS_ONE;
          end
        end
        S_OPEN: begin
          if (w_reopen) begin
            w_hold_nx = C_HOLD_FULL;
          end else if (close_req || (r_hold == '0)) begin
            w_state_nx = S_CLOSING;
          end else begin
            w_hold_nx = r_hold - C_HOLD_ONE;
          end
        end
        S_CLOSING: begin
          // Reopen keeps pos, so the return stroke is only as long as the
          // distance already closed.
          if (w_reopen) begin
            w_state_nx = S_OPENING;
          end else if (r_pos <= C_POS_ONE) begin
            w_pos_nx   = '0;
            w_state_nx = S_CLOSED;
          end else begin
            w_pos_nx = r_pos - C_POS_ONE;
          end
        end
        default: begin
          w_state_nx = S_CLOSED;
        end
      endcase
    end
  end

  // Output decode
  always_comb begin
    door_state  = r_state;
    door_open   = (r_state == S_OPEN);
    door_closed = (r_state == S_CLOSED);
    ok_to_move  = (r_state == S_CLOSED) & ~open_req & ~r_fault;
    door_floor  = r_door_floor;
    fault       = r_fault;
  end

endmodule
`default_nettype wire
